// File: rtl/eq_band_mixer.sv
// Equalizer band mixer: snapshots NBANDS band outputs per sample strobe, weights them through one
// shared multiplier and rounds to OUT_W. Define MIXER_SAT_EN to clamp instead of wrap on overflow.
module eq_band_mixer #(
    parameter int NBANDS    = 8,
    parameter int IN_W      = 32,
    parameter int GAIN_W    = 16,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NBANDS*IN_W-1:0]   band_in,
    input  logic                     gain_we,
    input  logic [2:0]               gain_addr,
    input  logic [GAIN_W-1:0]        gain_wdata,
    output logic [OUT_W-1:0]         y_out,
    output logic                     y_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic                     sat
);

    localparam int CNT_W     = $clog2(NBANDS);
    localparam int PROD_W    = IN_W + GAIN_W;
    localparam int ACC_W     = PROD_W + CNT_W;
    localparam int RND_SHIFT = 14 + OUT_SHIFT;

    localparam logic [GAIN_W-1:0]       GAIN_UNITY = GAIN_W'(16'd16384);
    localparam logic [CNT_W-1:0]        LAST_CNT   = CNT_W'(NBANDS - 1);
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1'b1) << (RND_SHIFT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    state_t                    state_r;
    logic signed [IN_W-1:0]    band_r     [NBANDS];
    logic signed [GAIN_W-1:0]  gain_sh_r  [NBANDS];
    logic signed [GAIN_W-1:0]  gain_act_r [NBANDS];
    logic signed [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [OUT_W-1:0]          y_out_r;
    logic                      y_valid_r;
    logic                      busy_r;
    logic                      overrun_r;
    logic                      sat_r;

    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   acc_next_s;
    logic signed [ACC_W-1:0]   round_sum_s;
    logic signed [ACC_W-1:0]   round_val_s;
    logic [OUT_W-1:0]          y_next_s;
    logic                      sat_next_s;

    // Shared multiplier and accumulator update for the band selected by cnt_r.
    always_comb begin
        prod_s     = PROD_W'(band_r[cnt_r]) * PROD_W'(gain_act_r[cnt_r]);
        acc_next_s = acc_r + ACC_W'(prod_s);
    end

`ifdef MIXER_SAT_EN
    // Round half up, then clamp to the signed OUT_W range.
    always_comb begin
        round_sum_s = acc_r + ROUND_BIAS;
        round_val_s = round_sum_s >>> RND_SHIFT;
        if ((&round_val_s[ACC_W-1:OUT_W-1]) || !(|round_val_s[ACC_W-1:OUT_W-1])) begin
            y_next_s   = round_val_s[OUT_W-1:0];
            sat_next_s = 1'b0;
        end else if (round_val_s[ACC_W-1]) begin
            y_next_s   = {1'b1, {(OUT_W-1){1'b0}}};
            sat_next_s = 1'b1;
        end else begin
            y_next_s   = {1'b0, {(OUT_W-1){1'b1}}};
            sat_next_s = 1'b1;
        end
    end
`else
    logic unused_round_s;

    // Round half up, then keep the low OUT_W bits (two's-complement wrap).
    always_comb begin
        round_sum_s = acc_r + ROUND_BIAS;
        round_val_s = round_sum_s >>> RND_SHIFT;
        y_next_s    = round_val_s[OUT_W-1:0];
        sat_next_s  = 1'b0;
    end

    assign unused_round_s = ^round_val_s[ACC_W-1:OUT_W];
`endif

    // Sample sequencer: IDLE accepts a strobe, MAC walks the bands, ROUND publishes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            acc_r     <= '0;
            cnt_r     <= '0;
            y_out_r   <= '0;
            y_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
            sat_r     <= 1'b0;
            for (int k = 0; k < NBANDS; k++) begin
                band_r[k]     <= '0;
                gain_sh_r[k]  <= GAIN_UNITY;
                gain_act_r[k] <= GAIN_UNITY;
            end
        end else begin
            y_valid_r <= 1'b0;
            overrun_r <= ena && (state_r != S_IDLE);
            if (gain_we && (int'(gain_addr) < NBANDS)) begin
                gain_sh_r[gain_addr] <= gain_wdata;
            end
            case (state_r)
                S_IDLE: begin
                    if (ena) begin
                        for (int k = 0; k < NBANDS; k++) begin
                            band_r[k] <= band_in[k*IN_W +: IN_W];
                        end
                        // Copy sees the pre-write shadow, so a same-cycle gain write waits a sample.
                        gain_act_r <= gain_sh_r;
                        acc_r      <= '0;
                        cnt_r      <= '0;
                        busy_r     <= 1'b1;
                        state_r    <= S_MAC;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_MAC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                    if (cnt_r == LAST_CNT) begin
                        state_r <= S_ROUND;
                    end else begin
                        state_r <= S_MAC;
                    end
                end
                S_ROUND: begin
                    y_out_r   <= y_next_s;
                    sat_r     <= sat_next_s;
                    y_valid_r <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign y_out   = y_out_r;
    assign y_valid = y_valid_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;
    assign sat     = sat_r;

endmodule

// File: doc/eq_band_mixer.md
# eq_band_mixer

- Downstream stage of the eight per-band FIR filter blocks in the equalizer datapath.
- On each sample strobe it snapshots the eight 32-bit band outputs and weights each by a programmable per-band gain, using one shared time-multiplexed multiplier.
- It then sums the weighted bands, rounds, and narrows the result to a 16-bit equalized sample for the output path.
- Gains are written through a simple register port and take effect on sample boundaries only, so a gain change never splits one output sample.

## Interface
- NBANDS, 8, number of bands summed.
- IN_W, 32, band input width (signed).
- GAIN_W, 16, gain width, signed Q2.14 (16384 = 1.0).
- OUT_W, 16, output width (signed).
- OUT_SHIFT, 15, extra right shift after gain scaling (removes filter coefficient fraction bits).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  sample strobe, same strobe that clocks the band filters; band_in is valid in this cycle.
- band_in  in  NBANDS*IN_W  band k at bits [k*IN_W +: IN_W], signed.
- gain_we  in  1  gain write enable.
- gain_addr  in  3  band index for the write; values ≥ NBANDS are ignored.
- gain_wdata  in  GAIN_W  signed gain value.
- y_out  out  OUT_W  mixed sample, signed, held until the next result.
- y_valid  out  1  one-cycle pulse when y_out updates.
- busy  out  1  high while a sample is being processed.
- overrun  out  1  one-cycle pulse when ena arrives while busy.
- sat  out  1  high with y_valid when the result was clipped.

## Operation
- Gain registers:
  - Shadow set: written by gain_we in any cycle.
  - Active set: copied from the shadow set when a sample is accepted.
  - Reset value of both sets: 16384 (unity).
- State machine: IDLE → MAC → ROUND → IDLE.
- IDLE:
  - ena=1: latch band_in, copy shadow gains to the active set, clear the accumulator and band counter, go to MAC, assert busy.
  - ena=0: stay in IDLE.
- MAC:
  - Each cycle: acc += band[cnt] * gain[cnt]. The product is IN_W+GAIN_W bits, signed.
  - The accumulator is IN_W+GAIN_W+clog2(NBANDS) bits (51 at defaults), so it cannot overflow.
  - cnt runs 0..NBANDS-1. After the last band, go to ROUND.
- ROUND:
  - r = (acc + 2^(13+OUT_SHIFT)) >>> (14+OUT_SHIFT), arithmetic shift, round half up.
  - Narrow r to OUT_W per Configuration; register y_out and sat; pulse y_valid; go to IDLE and deassert busy.
- ena while busy: the sample is dropped, overrun pulses for one cycle, and the computation in progress is unaffected.
- ena in the same cycle that ROUND exits: counted as busy, so it is dropped with an overrun pulse.
- gain_we in the same cycle as an accepted ena: the write lands in the shadow set and is not part of that copy. It applies from the next sample.
- Reset values: y_out=0, y_valid=0, busy=0, overrun=0, sat=0, state IDLE.
- Reset mid-operation: the computation is abandoned and no y_valid is issued.

## Timing
- Accepted ena in cycle T: MAC occupies T+1..T+NBANDS, ROUND is T+NBANDS+1, y_valid is high in cycle T+NBANDS+2 (T+10 at defaults).
- busy is high from T+1 through T+NBANDS+1.
- Minimum spacing between accepted strobes: NBANDS+2 cycles.
- y_out, y_valid, sat, overrun and busy are all registered; there are no combinational input-to-output paths.

## Configuration
- MIXER_SAT_EN defined:
  - If r exceeds the OUT_W signed range, clamp to +2^(OUT_W-1)-1 or -2^(OUT_W-1).
  - sat=1 with the corresponding y_valid.
- MIXER_SAT_EN undefined:
  - y_out = r[OUT_W-1:0], two's-complement wrap.
  - sat is tied to 0.

## Test plan
- Unity gains, band0 = 3276800, all other bands 0, ena pulse → y_out=100, y_valid exactly 10 cycles after ena, busy high for 9 cycles.
- Unity gains, band0 = -49152, others 0 → y_out = -1 (round half up from -1.5).
- Band0 = 32'h7FFF_FFFF, unity gain:
  - With MIXER_SAT_EN → y_out=32767, sat=1.
  - Without → y_out=16'h0000, sat=0.
- Write gain 0 to band 0 during MAC, band0=3276800, band1=3276800 → current y_out=200; next sample with the same inputs → y_out=100.
- ena reasserted 3 cycles after an accepted ena → overrun pulses once, the first result is still correct, and only one y_valid is produced.
- rst asserted for one cycle in the middle of MAC → busy=0 and y_out=0 the next cycle, no y_valid; all gains read back as unity on the next sample (band0=3276800 → y_out=100).
